// File: rtl/seg7_pkg.sv
// Shared widths and the active-low hex glyph table for the 7-segment scan path.
package seg7_pkg;

  localparam int IDX_W = 3;
  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph lookup (hex 0-F, active-low segments).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan: per-frame input snapshot, slot guard band,
// leading-zero blanking and frame-rate brightness PWM, registered pin outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIG     = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int BRIGHT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*N_DIG-1:0]   value,
  input  logic [N_DIG-1:0]     dig_en,
  input  logic                 lz_blank,
  input  logic [BRIGHT_W-1:0]  bright,
  output logic [N_DIG-1:0]     an,
  output logic [SEG_W-1:0]     seg,
  output logic [IDX_W-1:0]     digit_idx,
  output logic                 frame_sync
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;

  logic [4*N_DIG-1:0]  sh_val_q, sh_val_d;
  logic [N_DIG-1:0]    sh_en_q, sh_en_d;
  logic                sh_lz_q, sh_lz_d;
  logic [BRIGHT_W-1:0] sh_bright_q, sh_bright_d;

  logic [N_DIG-1:0]    an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic                frame_sync_q, frame_sync_d;

  logic                slot_end, frame_end;
  logic [NIB_W-1:0]    cur_nib;
  logic                cur_en, upper_zero, lz_hit, lit;
  logic [SEG_W-1:0]    dec_seg;

  // Prescaler, digit index, PWM phase and once-per-frame snapshot.
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    phase_d      = frame_end ? phase_q + 1'b1 : phase_q;
    sh_val_d     = sh_val_q;
    sh_en_d      = sh_en_q;
    sh_lz_d      = sh_lz_q;
    sh_bright_d  = sh_bright_q;
    if (frame_end) begin
      sh_val_d    = value;
      sh_en_d     = dig_en;
      sh_lz_d     = lz_blank;
      sh_bright_d = bright;
    end
    frame_sync_d = frame_end;
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    cur_nib    = '0;
    cur_en     = 1'b0;
    upper_zero = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib    = sh_val_q[4*k +: 4];
        cur_en     = sh_en_q[k];
        upper_zero = ((sh_val_q >> (4*k)) == '0);
      end
    end
    lz_hit = (idx_q != '0) && sh_lz_q && upper_zero;
    lit    = cur_en && (phase_q < sh_bright_q) && !lz_hit && (cnt_q >= BLANK_LIM);
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    for (int k = 0; k < N_DIG; k++) begin
      an_d[k] = !(lit && (idx_q == IDX_W'(k)));
    end
    seg_d       = lit ? dec_seg : SEG_OFF;
    digit_idx_d = idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      phase_q      <= '0;
      sh_val_q     <= '0;
      sh_en_q      <= '0;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      digit_idx_q  <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      sh_val_q     <= sh_val_d;
      sh_en_q      <= sh_en_d;
      sh_lz_q      <= sh_lz_d;
      sh_bright_q  <= sh_bright_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      digit_idx_q  <= digit_idx_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digit_idx  = digit_idx_q;
  assign frame_sync = frame_sync_q;

endmodule
